// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes, main-decoder ALU classes and R-type funct values.
package alu_pkg;
    localparam logic [3:0] ALU_CTL_AND  = 4'b0000;
    localparam logic [3:0] ALU_CTL_OR   = 4'b0001;
    localparam logic [3:0] ALU_CTL_ADD  = 4'b0010;
    localparam logic [3:0] ALU_CTL_MUL  = 4'b0011;
    localparam logic [3:0] ALU_CTL_SUB  = 4'b0110;
    localparam logic [3:0] ALU_CTL_SLT  = 4'b0111;
    localparam logic [3:0] ALU_CTL_NOR  = 4'b1100;
    localparam logic [3:0] ALU_CTL_NAND = 4'b1101;
    localparam logic [3:0] ALU_CTL_ILL  = 4'b1111;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_SLTI  = 2'b11;

    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_NAND = 6'b101111;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_MUL  = 6'b011000;
endpackage

// File: rtl/alu_ctl_decode.sv
// alu_ctl_decode: combinational (alu_op, funct) -> ALU control code and illegal flag.
module alu_ctl_decode
    import alu_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [5:0] funct_i,
    output logic [3:0] ctl_o,
    output logic       illegal_o
);
    logic [3:0] rtype_ctl;

    always_comb begin
        case (funct_i)
            FUNCT_AND:  rtype_ctl = ALU_CTL_AND;
            FUNCT_OR:   rtype_ctl = ALU_CTL_OR;
            FUNCT_ADD:  rtype_ctl = ALU_CTL_ADD;
            FUNCT_SUB:  rtype_ctl = ALU_CTL_SUB;
            FUNCT_NOR:  rtype_ctl = ALU_CTL_NOR;
            FUNCT_NAND: rtype_ctl = ALU_CTL_NAND;
            FUNCT_SLT:  rtype_ctl = ALU_CTL_SLT;
            FUNCT_MUL:  rtype_ctl = ALU_CTL_MUL;
            default:    rtype_ctl = ALU_CTL_ILL;
        endcase
    end

    assign ctl_o = alu_op_i == ALUOP_MEM  ? ALU_CTL_ADD :
                   alu_op_i == ALUOP_BR   ? ALU_CTL_SUB :
                   alu_op_i == ALUOP_SLTI ? ALU_CTL_SLT : rtype_ctl;
    assign illegal_o = alu_op_i == ALUOP_RTYPE && rtype_ctl == ALU_CTL_ILL;
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: register file, ALU-control decode and registered operand issue to the ALU.
// ALU_ISSUE_IMM_EN adds alu_src/imm16 so src2 can take a sign-extended immediate.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int AW     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW-1:0]     rs_addr,
    input  logic [AW-1:0]     rt_addr,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
`ifdef ALU_ISSUE_IMM_EN
    input  logic              alu_src,
    input  logic [15:0]       imm16,
`endif
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] src1,
    output logic [DATA_W-1:0] src2,
    output logic [3:0]        ALU_control,
    output logic              illegal
);
    logic [DATA_W-1:0] rf_q [NREG];
    logic [DATA_W-1:0] src1_q, src2_q, src1_d, src2_d, rt_val;
    logic [3:0]        ctl_q, ctl_d;
    logic              ill_q, ill_d, valid_q, accept, wr_hit;

    alu_ctl_decode u_dec (
        .alu_op_i  (alu_op),
        .funct_i   (funct),
        .ctl_o     (ctl_d),
        .illegal_o (ill_d)
    );

    assign in_ready = ~valid_q | out_ready;
    assign accept   = in_valid & in_ready;
    assign wr_hit   = wr_en & (wr_addr != '0);

    // Forward a same-cycle writeback so the issued operand is never stale.
    assign src1_d = rs_addr == '0 ? '0 : (wr_hit && wr_addr == rs_addr) ? wr_data : rf_q[rs_addr];
    assign rt_val = rt_addr == '0 ? '0 : (wr_hit && wr_addr == rt_addr) ? wr_data : rf_q[rt_addr];
`ifdef ALU_ISSUE_IMM_EN
    logic alu_src_q;
    assign src2_d = alu_src ? {{(DATA_W-16){imm16[15]}}, imm16} : rt_val;
`else
    assign src2_d = rt_val;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            ctl_q   <= '0;
            ill_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            if (wr_hit) rf_q[wr_addr] <= wr_data;
            if (accept) begin
                src1_q  <= src1_d;
                src2_q  <= src2_d;
                ctl_q   <= ctl_d;
                ill_q   <= ill_d;
                valid_q <= 1'b1;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef ALU_ISSUE_IMM_EN
    always_ff @(posedge clk) begin
        if (!rst) alu_src_q <= 1'b0;
        else if (accept) alu_src_q <= alu_src;
    end
`endif

    assign out_valid   = valid_q;
    assign src1        = src1_q;
    assign src2        = src2_q;
    assign ALU_control = ctl_q;
    assign illegal     = ill_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: randomized scoreboard bench for alu_issue_stage against a register-file/decode-table model.
module tb_alu_issue_stage;
    typedef struct {
        logic [31:0] s1;
        logic [31:0] s2;
        logic [3:0]  ctl;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b0;
    logic        in_valid = 1'b0, in_ready, wr_en = 1'b0, out_valid, out_ready = 1'b0, illegal;
    logic [4:0]  rs_addr = '0, rt_addr = '0, wr_addr = '0;
    logic [1:0]  alu_op = '0;
    logic [5:0]  funct = '0;
    logic [31:0] wr_data = '0, src1, src2;
    logic [3:0]  ALU_control;
`ifdef ALU_ISSUE_IMM_EN
    logic        alu_src = 1'b0;
    logic [15:0] imm16 = '0;
`endif

    int checks = 0, errors = 0;
    exp_t q[$];
    logic [31:0] ref_rf [32];
    logic        ref_ov = 1'b0;
    logic [3:0]  ftab [logic [5:0]];
    logic [3:0]  optab [logic [1:0]];
    logic [5:0]  legal_f [8] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010,
                                 6'b100111, 6'b101111, 6'b101010, 6'b011000};

    alu_issue_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .alu_op(alu_op), .funct(funct),
`ifdef ALU_ISSUE_IMM_EN
        .alu_src(alu_src), .imm16(imm16),
`endif
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .src1(src1), .src2(src2), .ALU_control(ALU_control), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; the model predicts the issued op from register contents before the edge.
    task automatic step(input logic iv, input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] op,
                        input logic [5:0] f, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic ordy);
        exp_t e;
        logic acc;
        in_valid = iv; rs_addr = rs; rt_addr = rt; alu_op = op; funct = f;
        wr_en = we; wr_addr = wa; wr_data = wd; out_ready = ordy;
        acc = iv && (!ref_ov || ordy);
        #1;
        chk("in_ready", {31'b0, in_ready}, {31'b0, !ref_ov || ordy});
        chk("out_valid", {31'b0, out_valid}, {31'b0, ref_ov});
        if (acc) begin
            e.s1 = (we && wa == rs && rs != 0) ? wd : ref_rf[rs];
            e.s2 = (we && wa == rt && rt != 0) ? wd : ref_rf[rt];
            if (op != 2'b10) begin e.ctl = optab[op]; e.ill = 1'b0; end
            else if (ftab.exists(f)) begin e.ctl = ftab[f]; e.ill = 1'b0; end
            else begin e.ctl = 4'hF; e.ill = 1'b1; end
            q.push_back(e);
        end
        @(posedge clk);
        if (we && wa != 0) ref_rf[wa] = wd;
        ref_ov = acc ? 1'b1 : (ordy ? 1'b0 : ref_ov);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] op, input logic [5:0] f);
        step(1'b1, rs, rt, op, f, 1'b0, 5'd0, 32'd0, 1'b1);
    endtask

    task automatic write(input logic [4:0] wa, input logic [31:0] wd);
        step(1'b0, 5'd0, 5'd0, 2'b00, 6'd0, 1'b1, wa, wd, 1'b1);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0; in_valid = 1'b0; wr_en = 1'b0; out_ready = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        q.delete();
        foreach (ref_rf[i]) ref_rf[i] = '0;
        ref_ov = 1'b0;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_src1", src1, 32'd0);
        chk("rst_src2", src2, 32'd0);
        chk("rst_ctl", {28'b0, ALU_control}, 32'd0);
        chk("rst_illegal", {31'b0, illegal}, 32'd0);
        rst = 1'b1;
    endtask

    // Monitor: pops on each consumed operation and verifies stalled outputs stay frozen.
    logic        was_stalled = 1'b0;
    logic [31:0] p_s1, p_s2;
    logic [3:0]  p_ctl;
    logic        p_ill;
    always @(negedge clk) begin
        if (!rst) begin
            was_stalled <= 1'b0;
        end else begin
            if (was_stalled) begin
                chk("hold_valid", {31'b0, out_valid}, 32'd1);
                chk("hold_src1", src1, p_s1);
                chk("hold_src2", src2, p_s2);
                chk("hold_ctl", {28'b0, ALU_control}, {28'b0, p_ctl});
                chk("hold_ill", {31'b0, illegal}, {31'b0, p_ill});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_issue", {31'b0, out_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("src1", src1, e.s1);
                    chk("src2", src2, e.s2);
                    chk("ALU_control", {28'b0, ALU_control}, {28'b0, e.ctl});
                    chk("illegal", {31'b0, illegal}, {31'b0, e.ill});
                end
            end
            was_stalled <= out_valid && !out_ready;
            p_s1 <= src1; p_s2 <= src2; p_ctl <= ALU_control; p_ill <= illegal;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++)
            ftab[legal_f[i]] = (i == 0) ? 4'b0000 : (i == 1) ? 4'b0001 : (i == 2) ? 4'b0010 :
                               (i == 3) ? 4'b0110 : (i == 4) ? 4'b1100 : (i == 5) ? 4'b1101 :
                               (i == 6) ? 4'b0111 : 4'b0011;
        optab[2'b00] = 4'b0010; optab[2'b01] = 4'b0110; optab[2'b11] = 4'b0111;
        @(posedge clk); #1;
        do_reset(2);
        issue(5'd0, 5'd0, 2'b10, 6'b100000);
        write(5'd5, 32'h0000_0007);
        write(5'd6, 32'hFFFF_FFF9);
        issue(5'd5, 5'd6, 2'b10, 6'b100000);
        step(1'b1, 5'd3, 5'd3, 2'b10, 6'b100101, 1'b1, 5'd3, 32'hA5A5_A5A5, 1'b1);
        write(5'd0, 32'h0000_1234);
        issue(5'd0, 5'd3, 2'b00, 6'd0);
        issue(5'd5, 5'd6, 2'b01, 6'd0);
        repeat (3) step(1'b1, 5'd6, 5'd5, 2'b11, 6'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        issue(5'd6, 5'd5, 2'b10, 6'b101010);
        issue(5'd1, 5'd2, 2'b10, 6'b111111);
        foreach (legal_f[i]) issue(5'(i), 5'(31 - i), 2'b10, legal_f[i]);
        issue(5'd5, 5'd6, 2'b00, 6'b111111);
        issue(5'd5, 5'd6, 2'b01, 6'b000000);
        issue(5'd5, 5'd6, 2'b11, 6'b101010);
        for (int n = 0; n < 400; n++) begin
            logic [5:0] f;
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : legal_f[$urandom_range(0, 7)];
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 2'($urandom_range(0, 3)), f, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 $urandom, $urandom_range(0, 3) != 0);
        end
        for (int n = 0; n < 40; n++)
            step(1'b1, 5'd5, 5'd5, 2'b00, 6'd0, 1'b1, 5'd5, $urandom, 1'b1);
        step(1'b1, 5'd5, 5'd6, 2'b10, 6'b100100, 1'b0, 5'd0, 32'd0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 2'b00, 6'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        do_reset(1);
        issue(5'd5, 5'd6, 2'b10, 6'b100000);
        step(1'b0, 5'd0, 5'd0, 2'b00, 6'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        @(negedge clk);
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
